// File: rtl/bicubic_pkg.sv
// Shared bicubic constants: Q1.8 weight scale, default widths, sum width and clamp limits.
// Used by the tap MAC and by the weight generators.
package bicubic_pkg;

    localparam int PIX_W_DEF  = 8;
    localparam int COEF_W_DEF = 9;
    localparam int FRAC_DEF   = 8;
    localparam int USER_W_DEF = 2;

    localparam int COEF_ONE  = 256;
    localparam int COEF_HALF = 128;

    // Signed 4-tap sum: product width + 1 carry bit + 1 sign bit + 1 headroom bit.
    localparam int SUM_W_DEF = PIX_W_DEF + COEF_W_DEF + 3;

    localparam int CLAMP_MIN = 0;
    localparam int CLAMP_MAX = (1 << PIX_W_DEF) - 1;

    function automatic int sum_w(input int pix_w, input int coef_w);
        return pix_w + coef_w + 3;
    endfunction

endpackage

// File: rtl/bicubic_tap4_mac_clamp_round.sv
// Combinational round-half-up, arithmetic shift by FRAC and clamp to [0, 2^PIX_W-1].
// o_clamped flags results that hit either limit.
module bicubic_clamp_round #(
    parameter int PIX_W = 8,
    parameter int FRAC  = 8,
    parameter int SUM_W = 20
) (
    input  logic signed [SUM_W-1:0] i_diff,
    output logic        [PIX_W-1:0] o_pix,
    output logic                    o_clamped
);

    localparam logic signed [SUM_W-1:0] RND_HALF = SUM_W'(1 << (FRAC - 1));
    localparam logic signed [SUM_W-1:0] PIX_MAX  = SUM_W'((1 << PIX_W) - 1);

    logic signed [SUM_W-1:0] w_rnd;
    logic signed [SUM_W-1:0] w_shr;

    assign w_rnd = i_diff + RND_HALF;
    assign w_shr = w_rnd >>> FRAC;

    always_comb begin
        o_pix     = '0;
        o_clamped = 1'b0;
        if (w_shr < 0) begin
            o_clamped = 1'b1;
        end else if (w_shr > PIX_MAX) begin
            o_pix     = '1;
            o_clamped = 1'b1;
        end else begin
            o_pix = w_shr[PIX_W-1:0];
        end
    end

endmodule

// File: rtl/bicubic_tap4_mac.sv
// 4-tap bicubic MAC (outer taps subtract, inner add), 3-cycle latency, one global stall: in_ready = out_ready | ~out_valid.
// Optional BICUBIC_MAC_SAT_CNT_EN adds sat_clr/sat_cnt, a saturating count of clamped output handshakes.
module bicubic_tap4_mac
    import bicubic_pkg::*;
#(
    parameter int PIX_W  = PIX_W_DEF,
    parameter int COEF_W = COEF_W_DEF,
    parameter int FRAC   = FRAC_DEF,
    parameter int USER_W = USER_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [PIX_W-1:0]  p0,
    input  logic [PIX_W-1:0]  p1,
    input  logic [PIX_W-1:0]  p2,
    input  logic [PIX_W-1:0]  p3,
    input  logic [COEF_W-1:0] w0,
    input  logic [COEF_W-1:0] w1,
    input  logic [COEF_W-1:0] w2,
    input  logic [COEF_W-1:0] w3,
    input  logic [USER_W-1:0] in_user,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [PIX_W-1:0]  out_pix,
    output logic [USER_W-1:0] out_user
`ifdef BICUBIC_MAC_SAT_CNT_EN
    ,
    input  logic              sat_clr,
    output logic [15:0]       sat_cnt
`endif
);

    localparam int M_W   = PIX_W + COEF_W;
    localparam int SUM_W = sum_w(PIX_W, COEF_W);

    logic w_adv;

    logic              r_s1_vld;
    logic [M_W-1:0]    r_m0, r_m1, r_m2, r_m3;
    logic [USER_W-1:0] r_s1_user;

    logic              r_s2_vld;
    logic [M_W:0]      r_pos, r_neg;
    logic [USER_W-1:0] r_s2_user;

    logic              r_s3_vld;
    logic [PIX_W-1:0]  r_out_pix;
    logic [USER_W-1:0] r_out_user;

    logic signed [SUM_W-1:0] w_diff;
    logic [PIX_W-1:0]        w_pix;
    logic                    w_clamped;

    // Every stage moves together; a held output freezes the whole pipe.
    assign w_adv     = out_ready | ~r_s3_vld;
    assign in_ready  = w_adv;
    assign out_valid = r_s3_vld;
    assign out_pix   = r_out_pix;
    assign out_user  = r_out_user;

    assign w_diff = $signed({2'b00, r_pos}) - $signed({2'b00, r_neg});

    bicubic_clamp_round #(
        .PIX_W (PIX_W),
        .FRAC  (FRAC),
        .SUM_W (SUM_W)
    ) u_clamp_round (
        .i_diff    (w_diff),
        .o_pix     (w_pix),
        .o_clamped (w_clamped)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_vld   <= 1'b0;
            r_m0       <= '0;
            r_m1       <= '0;
            r_m2       <= '0;
            r_m3       <= '0;
            r_s1_user  <= '0;
            r_s2_vld   <= 1'b0;
            r_pos      <= '0;
            r_neg      <= '0;
            r_s2_user  <= '0;
            r_s3_vld   <= 1'b0;
            r_out_pix  <= '0;
            r_out_user <= '0;
        end else if (w_adv) begin
            r_s1_vld   <= in_valid;
            r_m0       <= M_W'(p0) * M_W'(w0);
            r_m1       <= M_W'(p1) * M_W'(w1);
            r_m2       <= M_W'(p2) * M_W'(w2);
            r_m3       <= M_W'(p3) * M_W'(w3);
            r_s1_user  <= in_user;
            r_s2_vld   <= r_s1_vld;
            r_pos      <= {1'b0, r_m1} + {1'b0, r_m2};
            r_neg      <= {1'b0, r_m0} + {1'b0, r_m3};
            r_s2_user  <= r_s1_user;
            r_s3_vld   <= r_s2_vld;
            r_out_pix  <= w_pix;
            r_out_user <= r_s2_user;
        end
    end

`ifdef BICUBIC_MAC_SAT_CNT_EN
    logic        r_s3_clamped;
    logic [15:0] r_sat_cnt;

    assign sat_cnt = r_sat_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_clamped <= 1'b0;
            r_sat_cnt    <= '0;
        end else begin
            if (w_adv) begin
                r_s3_clamped <= w_clamped;
            end
            if (sat_clr) begin
                r_sat_cnt <= '0;
            end else if (r_s3_vld && out_ready && r_s3_clamped && (r_sat_cnt != 16'hFFFF)) begin
                r_sat_cnt <= r_sat_cnt + 16'd1;
            end
        end
    end
`else
    logic w_unused_clamped;
    assign w_unused_clamped = w_clamped;
`endif

endmodule

// File: tb/tb_bicubic_tap4_mac.sv
// Scoreboard bench for bicubic_tap4_mac: expected beats queued at accept, compared at output handshake.
module tb_bicubic_tap4_mac;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] p0, p1, p2, p3;
    logic [8:0] w0, w1, w2, w3;
    logic [1:0] in_user;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_pix;
    logic [1:0] out_user;
`ifdef BICUBIC_MAC_SAT_CNT_EN
    logic        sat_clr;
    logic [15:0] sat_cnt;
`endif

    always #5 clk = ~clk;

    bicubic_tap4_mac dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .p0        (p0),
        .p1        (p1),
        .p2        (p2),
        .p3        (p3),
        .w0        (w0),
        .w1        (w1),
        .w2        (w2),
        .w3        (w3),
        .in_user   (in_user),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_pix   (out_pix),
        .out_user  (out_user)
`ifdef BICUBIC_MAC_SAT_CNT_EN
        ,
        .sat_clr   (sat_clr),
        .sat_cnt   (sat_cnt)
`endif
    );

    int         n_checks = 0;
    int         n_pass   = 0;
    int         n_hs     = 0;
    logic [9:0] sb_q[$];
    bit         drv_done;

    function automatic logic [7:0] ref_pix(input logic [7:0] a0, a1, a2, a3,
                                           input logic [8:0] c0, c1, c2, c3);
        int s;
        s = int'(a1) * int'(c1) + int'(a2) * int'(c2) - int'(a0) * int'(c0) - int'(a3) * int'(c3) + 128;
        if (s < 0) return 8'd0;
        if (s / 256 > 255) return 8'd255;
        return 8'(s / 256);
    endfunction

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            logic [9:0] exp_beat;
            n_hs++;
            n_checks++;
            if (sb_q.size() == 0) begin
                $display("FAIL unexpected_output: got user=%0d pix=%0d, required no output", out_user, out_pix);
            end else begin
                exp_beat = sb_q.pop_front();
                if ({out_user, out_pix} !== exp_beat)
                    $display("FAIL scoreboard: got user=%0d pix=%0d, required user=%0d pix=%0d",
                             out_user, out_pix, exp_beat[9:8], exp_beat[7:0]);
                else
                    n_pass++;
            end
        end
    end

    task automatic send_beat(input logic [7:0] a0, a1, a2, a3, input logic [8:0] c0, c1, c2, c3,
                             input logic [1:0] u, output bit ok);
        p0 = a0; p1 = a1; p2 = a2; p3 = a3;
        w0 = c0; w1 = c1; w2 = c2; w3 = c3;
        in_user  = u;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (ok) begin
            @(posedge clk);
            sb_q.push_back({u, ref_pix(a0, a1, a2, a3, c0, c1, c2, c3)});
            #1;
        end else begin
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #1;
            if (sb_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #2;
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b, required 0", out_valid); else n_pass++;
        n_checks++;
        if (out_pix !== 8'd0) $display("FAIL reset_out_pix: got %0d, required 0", out_pix); else n_pass++;
        n_checks++;
        if (out_user !== 2'd0) $display("FAIL reset_out_user: got %0d, required 0", out_user); else n_pass++;
        n_checks++;
        if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b, required 1", in_ready); else n_pass++;
`ifdef BICUBIC_MAC_SAT_CNT_EN
        n_checks++;
        if (sat_cnt !== 16'd0) $display("FAIL reset_sat_cnt: got %0d, required 0", sat_cnt); else n_pass++;
`endif
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_latency;
        bit ok;
        send_beat(8'd10, 8'd77, 8'd200, 8'd30, 9'd0, 9'd256, 9'd0, 9'd0, 2'b10, ok);
        in_valid = 1'b0;
        n_checks++;
        if (!ok) $display("FAIL latency_accept: got no accept, required accept"); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL latency_c1: got out_valid=%b, required 0", out_valid); else n_pass++;
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) $display("FAIL latency_c2: got out_valid=%b, required 0", out_valid); else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({out_valid, out_user, out_pix} !== {1'b1, 2'b10, 8'd77})
            $display("FAIL latency_c3: got vld=%b user=%0d pix=%0d, required vld=1 user=2 pix=77",
                     out_valid, out_user, out_pix);
        else n_pass++;
        wait_drain(ok);
        n_checks++;
        if (!ok) $display("FAIL latency_drain: got %0d pending, required 0", sb_q.size()); else n_pass++;
    endtask

    task automatic test_directed;
        bit ok;
        bit all_ok;
        int hs0;
        all_ok = 1'b1;
        hs0 = n_hs;
        // Half-phase Keys weights, high clamp, low clamp, non-unity sum, all-zero weights.
        send_beat(8'd0, 8'd100, 8'd200, 8'd255, 9'd16, 9'd144, 9'd144, 9'd16, 2'b01, ok); all_ok &= ok;
        send_beat(8'd0, 8'd255, 8'd255, 8'd0, 9'd0, 9'd511, 9'd511, 9'd0, 2'b11, ok);     all_ok &= ok;
        send_beat(8'd255, 8'd0, 8'd0, 8'd255, 9'd511, 9'd0, 9'd0, 9'd511, 2'b00, ok);     all_ok &= ok;
        send_beat(8'd3, 8'd100, 8'd50, 8'd9, 9'd20, 9'd300, 9'd100, 9'd40, 2'b10, ok);    all_ok &= ok;
        send_beat(8'd99, 8'd99, 8'd99, 8'd99, 9'd0, 9'd0, 9'd0, 9'd0, 2'b01, ok);         all_ok &= ok;
        in_valid = 1'b0;
        n_checks++;
        if (!all_ok) $display("FAIL directed_accept: got a refused beat, required all accepted"); else n_pass++;
        wait_drain(ok);
        n_checks++;
        if (!ok || (n_hs - hs0) != 5)
            $display("FAIL directed_count: got %0d outputs, required 5", n_hs - hs0);
        else n_pass++;
    endtask

    task automatic test_backpressure;
        int hs0;
        hs0 = n_hs;
        drv_done  = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                bit ok;
                for (int i = 0; i < 20; i++) begin
                    send_beat(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
                              9'($urandom_range(0, 300)), 9'($urandom_range(0, 511)),
                              9'($urandom_range(0, 511)), 9'($urandom_range(0, 300)),
                              2'($urandom), ok);
                    n_checks++;
                    if (!ok) begin
                        $display("FAIL bp_accept: beat %0d got no accept, required accept", i);
                        break;
                    end
                    n_pass++;
                end
                in_valid = 1'b0;
                drv_done = 1'b1;
            end
            begin
                bit         seen;
                logic [9:0] cap;
                seen = 1'b0;
                for (int i = 0; i < 100; i++) begin
                    @(negedge clk);
                    if (out_valid) begin
                        seen = 1'b1;
                        break;
                    end
                end
                n_checks++;
                if (!seen) $display("FAIL bp_first_out: got no out_valid, required out_valid"); else n_pass++;
                n_checks++;
                if (in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b, required 0", in_ready); else n_pass++;
                cap = {out_user, out_pix};
                repeat (4) begin
                    @(negedge clk);
                    n_checks++;
                    if ({out_valid, in_ready, out_user, out_pix} !== {1'b1, 1'b0, cap})
                        $display("FAIL bp_hold: got vld=%b rdy=%b user=%0d pix=%0d, required vld=1 rdy=0 user=%0d pix=%0d",
                                 out_valid, in_ready, out_user, out_pix, cap[9:8], cap[7:0]);
                    else n_pass++;
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
                for (int i = 0; i < 400; i++) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                    if (drv_done && sb_q.size() == 0) break;
                end
                out_ready = 1'b1;
            end
        join
        n_checks++;
        if (sb_q.size() != 0 || (n_hs - hs0) != 20)
            $display("FAIL bp_count: got %0d outputs with %0d pending, required 20 and 0", n_hs - hs0, sb_q.size());
        else n_pass++;
    endtask

    task automatic test_reset_midflight;
        bit ok;
        bit all_ok;
        int hs0;
        out_ready = 1'b1;
        all_ok = 1'b1;
        send_beat(8'd1, 8'd11, 8'd12, 8'd2, 9'd0, 9'd256, 9'd0, 9'd0, 2'b01, ok); all_ok &= ok;
        send_beat(8'd1, 8'd21, 8'd22, 8'd2, 9'd0, 9'd256, 9'd0, 9'd0, 2'b10, ok); all_ok &= ok;
        send_beat(8'd1, 8'd31, 8'd32, 8'd2, 9'd0, 9'd256, 9'd0, 9'd0, 2'b11, ok); all_ok &= ok;
        rst_n = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        #1;
        n_checks++;
        if (!all_ok || out_valid !== 1'b0 || out_pix !== 8'd0)
            $display("FAIL midreset_clear: got vld=%b pix=%0d, required vld=0 pix=0", out_valid, out_pix);
        else n_pass++;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        hs0 = n_hs;
        send_beat(8'd5, 8'd140, 8'd90, 8'd7, 9'd0, 9'd0, 9'd256, 9'd0, 2'b10, ok);
        in_valid = 1'b0;
        wait_drain(ok);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (!ok || (n_hs - hs0) != 1)
            $display("FAIL midreset_first: got %0d outputs, required 1", n_hs - hs0);
        else n_pass++;
    endtask

`ifdef BICUBIC_MAC_SAT_CNT_EN
    task automatic test_sat_cnt;
        bit ok;
        bit seen;
        out_ready = 1'b1;
        sat_clr   = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        n_checks++;
        if (sat_cnt !== 16'd0) $display("FAIL sat_clear: got %0d, required 0", sat_cnt); else n_pass++;
        send_beat(8'd0, 8'd255, 8'd255, 8'd0, 9'd0, 9'd511, 9'd511, 9'd0, 2'b01, ok);
        in_valid = 1'b0;
        wait_drain(ok);
        n_checks++;
        if (sat_cnt !== 16'd1) $display("FAIL sat_high: got %0d, required 1", sat_cnt); else n_pass++;
        send_beat(8'd0, 8'd100, 8'd200, 8'd255, 9'd16, 9'd144, 9'd144, 9'd16, 2'b00, ok);
        in_valid = 1'b0;
        wait_drain(ok);
        n_checks++;
        if (sat_cnt !== 16'd1) $display("FAIL sat_noclamp: got %0d, required 1", sat_cnt); else n_pass++;
        out_ready = 1'b0;
        send_beat(8'd255, 8'd0, 8'd0, 8'd255, 9'd511, 9'd0, 9'd0, 9'd511, 2'b10, ok);
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        sat_clr   = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1 sat_clr = 1'b0;
        n_checks++;
        if (!seen || sat_cnt !== 16'd0 || sb_q.size() != 0)
            $display("FAIL sat_clr_wins: got cnt=%0d pending=%0d, required cnt=0 pending=0", sat_cnt, sb_q.size());
        else n_pass++;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        in_user   = '0;
        p0 = '0; p1 = '0; p2 = '0; p3 = '0;
        w0 = '0; w1 = '0; w2 = '0; w3 = '0;
`ifdef BICUBIC_MAC_SAT_CNT_EN
        sat_clr = 1'b0;
`endif
        test_reset();
        test_latency();
        test_directed();
        test_backpressure();
        test_reset_midflight();
`ifdef BICUBIC_MAC_SAT_CNT_EN
        test_sat_cnt();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/bicubic_tap4_mac.md
Name: bicubic_tap4_mac

Overview:
Consumer of the per-tap bicubic weights produced by the weight generators (x1/x2 and their mirrors). It takes four neighbour pixels and their four Q1.8 weight magnitudes and applies the Keys sign convention: outer taps subtract, inner taps add. It rounds, normalises by 2^8 and clamps the result to one output pixel. It is a 3-stage pipelined MAC with valid/ready on both sides, and sits between the line-buffer tap extractor and the next (vertical) pass or the output FIFO.

Parameters:
PIX_W, 8, pixel width (unsigned)
COEF_W, 9, weight magnitude width, unsigned Q1.8 (256 = 1.0)
FRAC, 8, fractional bits of weights; normalisation shift
USER_W, 2, sideband bits (e.g. sol/eol) carried alongside data

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
in_valid  in  1  input beat valid
in_ready  out  1  block can accept beat
p0,p1,p2,p3  in  PIX_W each  neighbour pixels; p1,p2 inner, p0,p3 outer
w0,w1,w2,w3  in  COEF_W each  weight magnitudes; w0,w3 outer (negative sense), w1,w2 inner (positive)
in_user  in  USER_W  sideband
out_valid  out  1  output beat valid
out_ready  in  1  downstream accepts
out_pix  out  PIX_W  interpolated, clamped pixel
out_user  out  USER_W  sideband aligned with out_pix

Behaviour:
- Reset (async assert, sync-release by clk domain upstream): all stage valids 0, out_valid=0, out_pix=0, out_user=0, all data regs 0.
- Global stall: adv = out_ready | ~out_valid. in_ready = adv (combinational). All three stages load only when adv=1; no bubble compression.
- Accept on in_valid & in_ready. Each stage's valid bit shifts by one on adv; S1 valid loads in_valid.
- S1: four unsigned products m_i = p_i * w_i, each PIX_W+COEF_W = 17 bits; register in_user.
- S2: pos = m1+m2, neg = m0+m3 (18 bits unsigned each).
- S3: s = pos - neg + 2^(FRAC-1), computed as 20-bit signed. Then r = s >>> FRAC (arithmetic). out_pix = 0 if r<0; 255 (2^PIX_W-1) if r>255; else r[7:0].
- Latency: 3 cycles accept-to-out_valid when unstalled. Throughput 1 beat/cycle.
- While out_valid=1 and out_ready=0: out_pix, out_user and all stages hold; in_ready=0.
- Same-cycle out handshake and new accept: legal; pipe advances normally.
- Weights are not checked for sum=256; non-unity sums pass through arithmetic unchanged, then clamp.
- Reset mid-operation: in-flight beats discarded, no partial output.

Optional Feature:
BICUBIC_MAC_SAT_CNT_EN
- Defined: extra ports sat_clr (in, 1) and sat_cnt (out, 16). sat_cnt increments on each output handshake whose S3 result was clamped (low or high). It saturates at 0xFFFF and is synchronously cleared by sat_clr; clear wins over an increment in the same cycle. Reset value 0.
- Undefined: ports, flag register and counter absent; no other change.

Decomposition:
- Package bicubic_pkg: COEF_ONE=256, COEF_HALF=128, FRAC default, sum width constant (PIX_W+COEF_W+3), clamp min/max constants. The same package is shared by the weight generators.
- One natural sub-module: bicubic_clamp_round (combinational round, shift and clamp of the S3 signed sum, plus the clamped flag output).

Test Plan:
- w=(0,256,0,0), p=(10,77,200,30) -> out_pix=77 after 3 cycles; out_user echoes in_user.
- Half-phase Keys weights w=(16,144,144,16), p=(0,100,200,255) -> sum 39120+128, out_pix=153.
- High clamp: w=(0,511,511,0), p=(0,255,255,0) -> r=1018, out_pix=255; with BICUBIC_MAC_SAT_CNT_EN, sat_cnt 0->1.
- Low clamp: w=(511,0,0,511), p=(255,0,0,255) -> negative sum, out_pix=0. sat_clr pulse in the same cycle as the handshake -> sat_cnt=0.
- Backpressure: continuous in_valid, out_ready low for 5 cycles after the first output -> in_ready=0 at the first cycle out_valid=1 and out_ready=0. Outputs hold stable; no beat lost or duplicated; sequence order preserved over 20 random beats against a reference model.
- Reset asserted with 3 beats in flight -> out_valid=0 immediately. After release, the first output is the first beat accepted post-reset.
